// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and state encoding for the multi-port register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;
  localparam int NUM_RD_DEF = 2;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: post-reset sweep FSM stepping clr_idx over every entry
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);
  state_t state, state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_we ? clr_idx + 1'b1 : clr_idx;
    end
  end
  // the last entry is all-ones, so the sweep ends on the edge that clears it
  always_comb state_nx = (state == CLEAR && clr_idx == '1) ? READY : state;
  always_comb begin
    clr_we = state == CLEAR;
    ready  = state == READY;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, NUM_RD registered read ports, zero register, clear sweep.
// Define REGFILE_BYPASS_EN for write-through forwarding on same-edge write/read collisions.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_we (clr_we),
    .clr_idx(clr_idx),
    .ready  (ready)
  );
  assign wr_ok = ready && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  always_ff @(posedge clk) begin
    if (rst_n && clr_we) mem[clr_idx] <= '0;
    else if (rst_n && wr_ok) mem[wr_addr] <= wr_data;
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] q, nxt;
    logic              zero;
    assign ra   = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && ra == '0;
`ifdef REGFILE_BYPASS_EN
    assign nxt = zero ? '0 : (wr_en && wr_addr == ra) ? wr_data : mem[ra];
`else
    assign nxt = zero ? '0 : mem[ra];
`endif
    always_ff @(posedge clk) q <= (rst_n && ready) ? nxt : '0;
    assign rd_data[i*DATA_W +: DATA_W] = q;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random checks of regfile_mp against a behavioural model
module tb_regfile_mp;
  logic        clk = 0;
  logic        rst_n, wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [11:0] rd_addr;
  logic [63:0] rd_data;
  logic        ready;
  int vectors = 0, miscompares = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  logic [31:0] m [64];
  int          swept = 0;
  logic        rdy_m = 0;
  logic [31:0] exp0 = 0, exp1 = 0;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [5:0] a, input logic we,
                                           input logic [5:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (BYP && we && wa == a) return wd;
    return m[a];
  endfunction

  task automatic tick(input logic rn, input logic we, input logic [5:0] wa,
                      input logic [31:0] wd, input logic [5:0] r0, input logic [5:0] r1);
    rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {r1, r0};
    if (!rn) begin
      rdy_m = 0; swept = 0; exp0 = 0; exp1 = 0;
    end else if (!rdy_m) begin
      swept++; exp0 = 0; exp1 = 0;
      if (swept == 64) begin
        rdy_m = 1;
        foreach (m[k]) m[k] = 0;
      end
    end else begin
      exp0 = model_rd(r0, we, wa, wd);
      exp1 = model_rd(r1, we, wa, wd);
      if (we && wa != 0) m[wa] = wd;
    end
    @(posedge clk); #1;
    check("ready", {31'b0, ready}, {31'b0, rdy_m});
    check("rd0", rd_data[31:0], exp0);
    check("rd1", rd_data[63:32], exp1);
  endtask

  initial begin
    rst_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    repeat (3) tick(0, 0, 0, 0, 0, 0);
    repeat (64) tick(1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 64; a += 2) tick(1, 0, 0, 0, 6'(a), 6'(a + 1));
    tick(1, 0, 0, 0, 6'd63, 6'd0);
    tick(1, 1, 12, 32'hDEADBEEF, 0, 0);
    tick(1, 0, 0, 0, 12, 13);
    tick(1, 0, 0, 0, 12, 12);
    tick(1, 1, 5, 32'h11, 0, 0);
    tick(1, 1, 5, 32'hA5A5A5A5, 5, 13);
    tick(1, 0, 0, 0, 5, 5);
    tick(1, 1, 0, 32'hFFFFFFFF, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 32'h12345678, 0, 0);
    tick(1, 1, 20, 32'h7, 0, 0);
    tick(1, 0, 0, 0, 20, 20);
    tick(0, 0, 0, 0, 20, 0);
    repeat (30) tick(1, 1, 40, 32'h55, 20, 40);
    tick(0, 1, 40, 32'h55, 20, 40);
    repeat (64) tick(1, 1, 40, 32'h55, 20, 40);
    tick(1, 0, 0, 0, 20, 40);
    tick(1, 0, 0, 0, 40, 12);
    for (int n = 0; n < 400; n++) begin
      logic [5:0] wa, r0, r1;
      wa = 6'($urandom_range(0, 7));
      r0 = 6'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 6'($urandom_range(0, 63));
      tick(($urandom_range(0, 199) != 0), 1'($urandom), wa, $urandom, r0, r1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
